pipe_hazard_ctrl: RTL and testbench

//  Parametrised stall/flush/valid controller for the in-order LC-3b pipeline.

---
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the LC-3b datapath (master) and the hazard controller (slave).
// Handshake: memory waits are level-based; a *_resp pulse completes the access it answers.
interface pipe_hazard_ctrl_if #(
  parameter int STAGES = 5,
  parameter int CNT_W  = 32
);
  logic              imem_resp;
  logic              dmem_req;
  logic              dmem_resp;
  logic              br_taken;
  logic              load_use;
  logic [STAGES-1:0] stage_load;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_flush;
  logic              pc_sel;
  logic              imem_read;
  logic              dmem_read;
  logic [CNT_W-1:0]  perf_cycles;
  logic [CNT_W-1:0]  perf_stalls;
  logic [CNT_W-1:0]  perf_flushes;
  logic [CNT_W-1:0]  perf_retired;

  modport master (
    output imem_resp, dmem_req, dmem_resp, br_taken, load_use,
    input  stage_load, stage_valid, stage_flush, pc_sel, imem_read, dmem_read,
    input  perf_cycles, perf_stalls, perf_flushes, perf_retired
  );

  modport slave (
    input  imem_resp, dmem_req, dmem_resp, br_taken, load_use,
    output stage_load, stage_valid, stage_flush, pc_sel, imem_read, dmem_read,
    output perf_cycles, perf_stalls, perf_flushes, perf_retired
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage load/valid/flush controller for the in-order LC-3b pipeline.
// Optional saturating performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int STAGES  = 5,
  parameter int MEM_IDX = 3,
  parameter int BR_IDX  = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;

  logic              imem_resp_m, dmem_resp_m;
  logic              if_rdy, mem_busy, mem_rdy, advance;
  logic              br_hit, lu_hit;
  logic [STAGES-1:0] load, flush;
  logic              pc_sel;

  // Memory responses are masked while reset is held so nothing advances under reset.
  assign imem_resp_m = reset & bus.imem_resp;
  assign dmem_resp_m = reset & bus.dmem_resp;

  assign if_rdy   = imem_resp_m | if_done_q;
  assign mem_busy = valid_q[MEM_IDX] & bus.dmem_req;
  assign mem_rdy  = ~mem_busy | dmem_resp_m | d_done_q;
  assign advance  = if_rdy & mem_rdy;
  assign br_hit   = valid_q[BR_IDX] & bus.br_taken;
  assign lu_hit   = valid_q[1] & bus.load_use;

  always_comb begin
    load    = '0;
    flush   = '0;
    pc_sel  = 1'b0;
    valid_d = valid_q;
    if (advance) begin
      load = '1;
      for (int k = 1; k < STAGES; k++) valid_d[k] = valid_q[k-1];
      valid_d[0] = 1'b1;
      if (br_hit) begin
        pc_sel = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
          if (k <= BR_IDX) begin
            flush[k]   = 1'b1;
            valid_d[k] = 1'b0;
          end
        end
      end else if (lu_hit) begin
        // PC and latch 1 hold the dependent instruction; a bubble goes into latch 2.
        load[1:0]  = 2'b00;
        flush[2]   = 1'b1;
        valid_d[2] = 1'b0;
        valid_d[1] = valid_q[1];
        valid_d[0] = valid_q[0];
      end
    end
  end

  // A fetch that completes while the PC is frozen is remembered until the PC loads.
  assign if_done_d = load[0] ? 1'b0 : (if_done_q | imem_resp_m);
  assign d_done_d  = advance ? 1'b0 : (d_done_q | dmem_resp_m);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= {{(STAGES-1){1'b0}}, 1'b1};
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      if_done_q <= if_done_d;
      d_done_q  <= d_done_d;
    end
  end

  assign bus.stage_load  = load;
  assign bus.stage_valid = valid_q;
  assign bus.stage_flush = flush;
  assign bus.pc_sel      = pc_sel;
  assign bus.imem_read   = ~if_done_q;
  assign bus.dmem_read   = mem_busy & ~d_done_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cycles_q, stalls_q, flushes_q, retired_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles_q  <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
      retired_q <= '0;
    end else begin
      cycles_q  <= sat_inc(cycles_q, 1'b1);
      stalls_q  <= sat_inc(stalls_q, ~load[0]);
      flushes_q <= sat_inc(flushes_q, advance & br_hit);
      retired_q <= sat_inc(retired_q, advance & valid_q[STAGES-1]);
    end
  end

  assign bus.perf_cycles  = cycles_q;
  assign bus.perf_stalls  = stalls_q;
  assign bus.perf_flushes = flushes_q;
  assign bus.perf_retired = retired_q;
`else
  assign bus.perf_cycles  = {CNT_W{1'b0}};
  assign bus.perf_stalls  = {CNT_W{1'b0}};
  assign bus.perf_flushes = {CNT_W{1'b0}};
  assign bus.perf_retired = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;
  localparam int STAGES = 5;
  localparam int CNT_W  = 4;
  localparam int W      = 3 * STAGES + 3;

  logic clk;
  logic reset;

  pipe_hazard_ctrl_if #(.STAGES(STAGES), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .STAGES (STAGES),
    .MEM_IDX(3),
    .BR_IDX (2),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           step_id  = 0;
  int           chk_cnt  = 0;
  int           pass_cnt = 0;

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      int id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      chk("stage_load",  id, {3'b0, bus.stage_load},  {3'b0, e[17:13]});
      chk("stage_valid", id, {3'b0, bus.stage_valid}, {3'b0, e[12:8]});
      chk("stage_flush", id, {3'b0, bus.stage_flush}, {3'b0, e[7:3]});
      chk("pc_sel",      id, {7'b0, bus.pc_sel},      {7'b0, e[2]});
      chk("imem_read",   id, {7'b0, bus.imem_read},   {7'b0, e[1]});
      chk("dmem_read",   id, {7'b0, bus.dmem_read},   {7'b0, e[0]});
    end
  end

  // driver: apply one cycle of inputs and queue the outputs expected in that cycle
  task automatic step(input logic ir, input logic dq, input logic dr, input logic br,
                      input logic lu, input logic [4:0] el, input logic [4:0] ev,
                      input logic [4:0] ef, input logic epc, input logic eir, input logic edr);
    bus.imem_resp = ir;
    bus.dmem_req  = dq;
    bus.dmem_resp = dr;
    bus.br_taken  = br;
    bus.load_use  = lu;
    exp_q.push_back({el, ev, ef, epc, eir, edr});
    id_q.push_back(step_id);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt_val(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    chk(name, step_id, {4'b0, act}, {4'b0, exp});
  endtask

  initial begin
    reset         = 1'b0;
    bus.imem_resp = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_resp = 1'b0;
    bus.br_taken  = 1'b0;
    bus.load_use  = 1'b0;
    @(posedge clk);
    #1;

    // reset state, responses ignored
    step(1,0,1,0,0, 5'b00000, 5'b00001, 5'b00000, 0,1,0);
    step(1,0,1,0,0, 5'b00000, 5'b00001, 5'b00000, 0,1,0);
    reset = 1'b1;

    // fill
    step(1,0,0,0,0, 5'b11111, 5'b00001, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b00011, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b00111, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b01111, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b11111, 5'b00000, 0,1,0);

    // split I/D waits: fetch first, then data
    step(0,1,0,0,0, 5'b00000, 5'b11111, 5'b00000, 0,1,1);
    step(1,1,0,0,0, 5'b00000, 5'b11111, 5'b00000, 0,1,1);
    step(0,1,0,0,0, 5'b00000, 5'b11111, 5'b00000, 0,0,1);
    step(0,1,0,0,0, 5'b00000, 5'b11111, 5'b00000, 0,0,1);
    step(0,1,1,0,0, 5'b11111, 5'b11111, 5'b00000, 0,0,1);
    // data first, then fetch
    step(0,1,1,0,0, 5'b00000, 5'b11111, 5'b00000, 0,1,1);
    step(0,1,0,0,0, 5'b00000, 5'b11111, 5'b00000, 0,1,0);
    step(1,1,0,0,0, 5'b11111, 5'b11111, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b11111, 5'b00000, 0,1,0);

    // load-use bubble
    step(1,0,0,0,1, 5'b11100, 5'b11111, 5'b00100, 0,1,0);
    step(0,0,0,0,0, 5'b11111, 5'b11011, 5'b00000, 0,0,0);
    step(1,0,0,0,0, 5'b11111, 5'b10111, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b01111, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b11111, 5'b00000, 0,1,0);

    // branch beats load-use; hazards in invalid stages ignored; stalled branch waits
    step(1,0,0,1,1, 5'b11111, 5'b11111, 5'b00110, 1,1,0);
    step(1,0,0,1,1, 5'b11111, 5'b11001, 5'b00000, 0,1,0);
    step(1,1,0,0,0, 5'b11111, 5'b10011, 5'b00000, 0,1,0);
    step(0,0,0,1,0, 5'b00000, 5'b00111, 5'b00000, 0,1,0);
    step(1,0,0,1,0, 5'b11111, 5'b00111, 5'b00110, 1,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b01001, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b10011, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b00111, 5'b00000, 0,1,0);

    // reset mid data wait with d_done set
    step(0,1,1,0,0, 5'b00000, 5'b01111, 5'b00000, 0,1,1);
    step(0,1,0,0,0, 5'b00000, 5'b01111, 5'b00000, 0,1,0);
    reset = 1'b0;
    step(1,1,1,0,0, 5'b00000, 5'b00001, 5'b00000, 0,1,0);
    step(1,1,1,0,0, 5'b00000, 5'b00001, 5'b00000, 0,1,0);
    reset = 1'b1;
    step(1,0,0,0,0, 5'b11111, 5'b00001, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b00011, 5'b00000, 0,1,0);
    step(1,0,0,0,0, 5'b11111, 5'b00111, 5'b00000, 0,1,0);
    step(1,1,0,0,0, 5'b00000, 5'b01111, 5'b00000, 0,1,1);
    step(0,1,1,0,0, 5'b11111, 5'b01111, 5'b00000, 0,0,1);
    for (int i = 0; i < 12; i++) step(1,0,0,0,0, 5'b11111, 5'b11111, 5'b00000, 0,1,0);

    // counters: 17 cycles since reset release, 1 stall, no flush, 12 retired
`ifdef PIPE_PERF_CNT_EN
    chk_cnt_val("perf_cycles",  bus.perf_cycles,  4'd15);
    chk_cnt_val("perf_stalls",  bus.perf_stalls,  4'd1);
    chk_cnt_val("perf_flushes", bus.perf_flushes, 4'd0);
    chk_cnt_val("perf_retired", bus.perf_retired, 4'd12);
`else
    chk_cnt_val("perf_cycles",  bus.perf_cycles,  4'd0);
    chk_cnt_val("perf_stalls",  bus.perf_stalls,  4'd0);
    chk_cnt_val("perf_flushes", bus.perf_flushes, 4'd0);
    chk_cnt_val("perf_retired", bus.perf_retired, 4'd0);
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
